qk_result_drain: RTL and testbench

//  Read-side bridge behind the Qn*KnT multi_matmul_wrapper, mirroring the LP->matmul ping-pong bridge.

---
 rtl/qk_result_drain.sv | 169 ++++++++++++++++
 tb/tb_qk_result_drain.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qk_result_drain.sv
// Double-buffered capture of multi-row matmul results, drained row by row over valid/ready.
// One bank fills from acc_done_wrap captures while the other streams to the scale/softmax stage.
module qk_result_drain #(
    parameter int DATA_W        = 256,
    parameter int TOTAL_INPUT_W = 4,
    parameter int NUM_TILES     = 4,
    localparam int ROW_IW       = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1,
    localparam int TILE_IW      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data [TOTAL_INPUT_W],
    output logic                stall,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ROW_IW-1:0]   out_row,
    output logic [TILE_IW-1:0]  out_tile,
    output logic                out_last,
    output logic                bank_done,
    output logic                overflow
);

    localparam logic [ROW_IW-1:0]  ROW_LAST  = ROW_IW'(TOTAL_INPUT_W - 1);
    localparam logic [TILE_IW-1:0] TILE_LAST = TILE_IW'(NUM_TILES - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state, state_nxt;

    logic               wr_bank;
    logic               rd_bank;
    logic [TILE_IW-1:0] wr_tile;
    logic [TILE_IW-1:0] rd_tile;
    logic [ROW_IW-1:0]  rd_row;
    logic [1:0]         full;
    logic [1:0]         full_nxt;

    logic capture;
    logic wr_last;
    logic beat;
    logic rd_last;
    logic release_bank;

    logic [DATA_W-1:0] mem [2][NUM_TILES][TOTAL_INPUT_W];

    // stall is decoded purely from registers so the controller sees it before it fires a capture.
    assign stall        = full[wr_bank];
    assign capture      = in_valid && !stall && !clear;
    assign wr_last      = (wr_tile == TILE_LAST);
    assign out_valid    = (state == STREAM);
    assign beat         = out_valid && out_ready && !clear;
    assign rd_last      = (rd_tile == TILE_LAST) && (rd_row == ROW_LAST);
    assign release_bank = beat && rd_last;

    assign out_data = out_valid ? mem[rd_bank][rd_tile][rd_row] : '0;
    assign out_row  = out_valid ? rd_row  : '0;
    assign out_tile = out_valid ? rd_tile : '0;
    assign out_last = out_valid && rd_last;

    // NOTE: storage has no reset; a bank is only ever read after all its words were written,
    // and leaving it reset-free lets synthesis map it onto LUTRAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_bank][wr_tile] <= in_data;
        end
    end

    // NOTE: every signal assigned in an always_comb gets its default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        full_nxt = full;
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
        // A capture can only target the bank being released if that bank was full, in which case
        // capture is already blocked by stall; both updates therefore never collide.
        if (capture && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (release_bank) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_tile   <= '0;
            rd_tile   <= '0;
            rd_row    <= '0;
            full      <= 2'b00;
            bank_done <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_tile   <= '0;
            rd_tile   <= '0;
            rd_row    <= '0;
            full      <= 2'b00;
            bank_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            full      <= full_nxt;
            bank_done <= release_bank;

            if (in_valid && stall) begin
                overflow <= 1'b1;
            end

            if (capture) begin
                if (wr_last) begin
                    wr_tile <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_tile <= wr_tile + 1'b1;
                end
            end

            // Read pointers walk tile-major, row-minor and wrap to zero at the end of a bank.
            if (beat) begin
                if (rd_row == ROW_LAST) begin
                    rd_row <= '0;
                    if (rd_tile == TILE_LAST) begin
                        rd_tile <= '0;
                        rd_bank <= ~rd_bank;
                    end else begin
                        rd_tile <= rd_tile + 1'b1;
                    end
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qk_result_drain.sv
// Randomised scoreboard bench for qk_result_drain: a bank-level reference model queues the
// expected beats at capture time and an independent monitor pops them on each handshake.
module tb_qk_result_drain;

    localparam int DATA_W = 256;
    localparam int TIW    = 4;
    localparam int NT     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data [TIW];
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_tile;
    logic              out_last;
    logic              bank_done;
    logic              overflow;

    qk_result_drain #(
        .DATA_W        (DATA_W),
        .TOTAL_INPUT_W (TIW),
        .NUM_TILES     (NT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_tile  (out_tile),
        .out_last  (out_last),
        .bank_done (bank_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                row;
        int                tile;
        bit                last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] part [NT][TIW];
    logic [DATA_W-1:0] cur_d [TIW];
    int                m_tile;
    int                completed;
    int                released;
    bit                exp_overflow;
    int                n_checks;
    int                n_fail;
    int                done_seen;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int held();
        return completed - released;
    endfunction

    // Reference model: a bank is a list of TIW x NT words emitted tile-major; at most two banks
    // may be held (completed but not fully drained) before further captures are dropped.
    task automatic model_capture();
        beat_t b;
        for (int r = 0; r < TIW; r++) part[m_tile][r] = cur_d[r];
        m_tile++;
        if (m_tile == NT) begin
            for (int t = 0; t < NT; t++) begin
                for (int r = 0; r < TIW; r++) begin
                    b.data = part[t][r];
                    b.row  = r;
                    b.tile = t;
                    b.last = (t == NT - 1) && (r == TIW - 1);
                    exp_q.push_back(b);
                end
            end
            completed++;
            m_tile = 0;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_tile       = 0;
        completed    = released;
        exp_overflow = 1'b0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < TIW; r++)
            for (int w = 0; w < DATA_W / 32; w++) cur_d[r][w*32 +: 32] = $urandom;
    endtask

    task automatic fill_pattern(input int t);
        for (int r = 0; r < TIW; r++) cur_d[r] = DATA_W'(16 * t + r);
    endtask

    // One clock: inputs driven at +1 after the edge, model updated on the edge that samples them.
    task automatic drive_cycle(input bit v, input bit rdy, input bit clr);
        bit accept;
        in_valid  = v;
        in_data   = cur_d;
        out_ready = rdy;
        clear     = clr;
        accept    = v && !clr && (held() < 2);
        @(posedge clk);
        if (clr) model_flush();
        else if (v) begin
            if (accept) model_capture();
            else exp_overflow = 1'b1;
        end
        #1;
    endtask

    task automatic wait_drain(input bit rand_ready, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            drive_cycle(1'b0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        check("drain_timeout", DATA_W'(exp_q.size()), 0);
    endtask

    // Monitor: scoreboard pops on handshakes, plus per-cycle stall/overflow/bank_done/hold checks.
    initial begin
        beat_t             e;
        bit                rel_now;
        bit                done_due;
        bit                hold_prev;
        logic [DATA_W-1:0] h_data;
        logic [1:0]        h_row;
        logic [1:0]        h_tile;
        logic              h_last;
        rel_now   = 0;
        done_due  = 0;
        hold_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rel_now   = 0;
                done_due  = 0;
                hold_prev = 0;
            end else begin
                check("stall", stall, held() == 2);
                check("overflow", overflow, exp_overflow);
                check("bank_done", bank_done, done_due);
                if (bank_done) done_seen++;
                done_due = 0;
                if (hold_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, h_data);
                    check("hold_row", out_row, h_row);
                    check("hold_tile", out_tile, h_tile);
                    check("hold_last", out_last, h_last);
                end
                hold_prev = out_valid && !out_ready && !clear;
                h_data = out_data;
                h_row  = out_row;
                h_tile = out_tile;
                h_last = out_last;
                if (out_valid && out_ready && !clear) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_row", out_row, e.row);
                        check("beat_tile", out_tile, e.tile);
                        check("beat_last", out_last, e.last);
                        if (e.last) begin
                            rel_now  = 1;
                            done_due = 1;
                        end
                    end
                end
            end
            @(posedge clk);
            if (rel_now && !rst) released++;
            rel_now = 0;
        end
    end

    initial begin
        int n;
        int d0;
        n_checks = 0; n_fail = 0; done_seen = 0;
        m_tile = 0; completed = 0; released = 0; exp_overflow = 0;
        for (int r = 0; r < TIW; r++) cur_d[r] = '0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = cur_d;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: async reset in the middle of a stream.
        for (int t = 0; t < NT; t++) begin fill_random(); drive_cycle(1'b1, 1'b0, 1'b0); end
        repeat (4) drive_cycle(1'b0, 1'b1, 1'b0);
        check("t1_streaming", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_done", bank_done, 0);
        check("t1_rst_stall", stall, 0);
        check("t1_rst_overflow", overflow, 0);
        @(posedge clk);
        @(posedge clk);
        model_flush();
        #1 rst = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        check("t1_idle_after", out_valid, 0);

        // Test 2: one bank of patterned data with out_ready held high.
        d0 = done_seen;
        for (int t = 0; t < NT; t++) begin fill_pattern(t); drive_cycle(1'b1, 1'b1, 1'b0); end
        wait_drain(1'b0, n);
        drive_cycle(1'b0, 1'b1, 1'b0);
        check("t2_one_done", DATA_W'(done_seen - d0), 1);

        // Test 3: same pattern under random backpressure, first out_valid at T+2.
        for (int t = 0; t < NT; t++) begin fill_pattern(t); drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0); end
        check("t3_valid_T1", out_valid, 0);
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("t3_valid_T2", out_valid, 1);
        wait_drain(1'b1, n);

        // Test 4: fill both banks, drop a ninth capture, then drain both with one bubble.
        for (int i = 0; i < 2 * NT; i++) begin fill_random(); drive_cycle(1'b1, 1'b0, 1'b0); end
        check("t4_stall", stall, 1);
        fill_random();
        drive_cycle(1'b1, 1'b0, 1'b0);
        check("t4_overflow", overflow, 1);
        wait_drain(1'b0, n);
        check("t4_drain_cycles", DATA_W'(n), 2 * TIW * NT + 1);

        // Test 5: last beat of bank0 and the capture completing bank1 in the same cycle.
        drive_cycle(1'b0, 1'b0, 1'b1);
        check("t5_clear_overflow", overflow, 0);
        for (int i = 0; i < 2 * NT - 1; i++) begin fill_random(); drive_cycle(1'b1, 1'b0, 1'b0); end
        n = 0;
        while (!(out_valid && out_last) && n < 100) begin drive_cycle(1'b0, 1'b1, 1'b0); n++; end
        check("t5_reach_last", out_last, 1);
        fill_random();
        drive_cycle(1'b1, 1'b1, 1'b0);
        check("t5_bubble", out_valid, 0);
        check("t5_no_stall", stall, 0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        check("t5_bank1_valid", out_valid, 1);
        check("t5_bank1_tile", out_tile, 0);
        wait_drain(1'b0, n);
        check("t5_no_drop", overflow, 0);

        // Test 6: clear while beat 7 is presented, then a fresh bank from tile 0 row 0.
        for (int t = 0; t < NT; t++) begin fill_random(); drive_cycle(1'b1, 1'b0, 1'b0); end
        drive_cycle(1'b0, 1'b0, 1'b0);
        repeat (6) drive_cycle(1'b0, 1'b1, 1'b0);
        check("t6_beat7_tile", out_tile, 1);
        check("t6_beat7_row", out_row, 2);
        drive_cycle(1'b0, 1'b1, 1'b1);
        check("t6_valid_after_clear", out_valid, 0);
        check("t6_row_after_clear", out_row, 0);
        check("t6_tile_after_clear", out_tile, 0);
        for (int t = 0; t < NT; t++) begin fill_random(); drive_cycle(1'b1, 1'b0, 1'b0); end
        drive_cycle(1'b0, 1'b0, 1'b0);
        check("t6_restart_row", out_row, 0);
        check("t6_restart_tile", out_tile, 0);
        wait_drain(1'b1, n);

        // Random phase: captures, backpressure and occasional clears.
        for (int i = 0; i < 2000; i++) begin
            fill_random();
            drive_cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 60, $urandom_range(0, 299) == 0);
        end
        wait_drain(1'b0, n);
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
